elastic_pipeline: RTL and testbench
===================================

# elastic_pipeline

Parametrised valid/ready pipeline register chain that replaces the plain delay-line pipeline wherever backpressure exists. It adds per-stage valid tracking, bubble collapsing, an occupancy count and an optional flush. It sits between GeneSys datapath producers and consumers, such as the SIMD lanes and buffer read ports, that cannot guarantee a consumer is always ready.

## Interface
- NUM_BITS, 16, payload width.
- NUM_STAGES, 1, register stages (≥0); 0 = combinational passthrough.
- EN_RESET, 0, 1 = data registers cleared on rst; 0 = only valid bits and counter reset.
- CNT_W, $clog2(NUM_STAGES+1), occupancy width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  NUM_BITS  input payload.
- in_valid  in  1  producer has data.
- in_ready  out  1  pipeline accepts this cycle.
- data_out  out  NUM_BITS  payload of last stage.
- out_valid  out  1  last stage holds data.
- out_ready  in  1  consumer accepts.
- occupancy  out  CNT_W  number of valid stages.
- flush  in  1  present only with ELASTIC_PIPE_FLUSH_EN.

## Operation
- Stage i holds data[i] and valid[i]. Stage 0 is the input side; stage N-1 drives the outputs.
- Ready chain: rdy[N] = out_ready; rdy[i] = !valid[i] | rdy[i+1]. in_ready = rdy[0], which is combinational.
- Stage i loads when rdy[i] is high:
  - Stage 0 loads data_in and valid = in_valid.
  - Stage i>0 loads stage i-1 and valid[i-1].
- Bubbles collapse: an empty stage always accepts, even while out_ready is low.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- occupancy is a registered counter:
  - +1 on accept only.
  - -1 on emit only.
  - Unchanged on both or neither.
  - Must always equal popcount(valid); the bench checks this as an assertion.
- Data is never dropped or duplicated. Order is strictly FIFO.
- in_valid deasserting without accept is legal (no producer-side hold rule). Consumer side: out_valid, once high, holds with data_out stable until emit.
- NUM_STAGES = 0:
  - data_out = data_in, out_valid = in_valid, in_ready = out_ready.
  - occupancy is a constant 0.
  - flush is ignored.

## Timing
- Reset values: all valid = 0, out_valid = 0, occupancy = 0. data_out = 0 if EN_RESET = 1, otherwise undefined. in_ready = 1 the cycle after reset (N ≥ 1).
- rst has priority over all other inputs. Reset mid-stream discards all held data without emitting.
- Latency: data accepted at edge t is first presented at data_out/out_valid after edge t+N-1. With the consumer always ready, that is N cycles from accept to emit.
- Throughput: one transfer per cycle whenever out_ready is high.
- Full: all N valid and out_ready = 0 gives in_ready = 0. If out_ready rises, in_ready rises in the same cycle, and simultaneous accept and emit leave occupancy unchanged.
- Empty: out_valid = 0. data_out holds the last value and is don't-care.

## Configuration
- ELASTIC_PIPE_FLUSH_EN defined: flush port exists.
  - In a flush cycle, in_ready = 0 and out_valid = 0, so no transfers occur.
  - At the next edge all valid bits and occupancy clear.
  - rst has priority over flush.
- Not defined: no flush port, and the pipeline drains only through emits.

## Structure
- Shared package genesys_pipe_pkg holds:
  - the clog2-based occupancy-width function;
  - a common stage_t-style packed struct {valid, data} parameter helper.
- Sub-module pipe_stage holds one data register plus valid, with load/clear/EN_RESET behaviour. It is instantiated NUM_STAGES times in a generate loop.
- The top level holds the ready chain, occupancy counter and N = 0 bypass.

## Test plan
- N=3, W=16, out_ready=1, stream 0x0001..0x0010 back-to-back → out_valid first rises 3 cycles after the first accept, outputs in order, 1/cycle, occupancy steady at 3.
- N=3, out_ready=0, in_valid=1 with 0xA,0xB,0xC,0xD → first three accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready → 0xA emitted and 0xD accepted in the same cycle, occupancy stays 3.
- N=4, a single item 0x55 then idle, with out_ready toggling 0/1 → 0x55 emitted exactly once, data_out stable while stalled, occupancy returns to 0.
- N=3, pipeline full, rst pulsed for 1 cycle → out_valid=0, occupancy=0, in_ready=1 next cycle. With EN_RESET=1, data_out=0.
- With ELASTIC_PIPE_FLUSH_EN, N=3, two items held, flush=1 with in_valid=1 → no accept and no emit that cycle, occupancy=0 afterwards, and the next item 0x77 emerges after 3 cycles.
- N=0, in_valid/out_ready random → out mirrors in combinationally and occupancy stays 0.

Source files
------------

// File: rtl/genesys_pipe_pkg.sv
// genesys_pipe_pkg: shared sizing helpers for the GeneSys valid/ready pipeline blocks
package genesys_pipe_pkg;

    // Occupancy counter width: enough bits to count 0..n, never narrower than one bit
    function automatic int occ_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to hold one {valid, data} stage of a w-bit payload
    function automatic int stage_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic pipeline register holding a payload and its valid bit
module pipe_stage
    import genesys_pipe_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter bit EN_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [NUM_BITS-1:0] i_data,
    output logic                o_valid,
    output logic [NUM_BITS-1:0] o_data
);

    typedef struct packed {
        logic                valid;
        logic [NUM_BITS-1:0] data;
    } stage_t;

    stage_t r_stage;

    // Reset beats clear beats load; payload is only captured for a real item so an emptied stage keeps its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage.valid <= 1'b0;
            if (EN_RESET) r_stage.data <= '0;
        end else if (i_clear) begin
            r_stage.valid <= 1'b0;
        end else if (i_load) begin
            r_stage.valid <= i_valid;
            if (i_valid) r_stage.data <= i_data;
        end
    end

    assign o_valid = r_stage.valid;
    assign o_data  = r_stage.data;

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: valid/ready register chain with bubble collapsing and occupancy count; ELASTIC_PIPE_FLUSH_EN adds a flush port
module elastic_pipeline
    import genesys_pipe_pkg::*;
#(
    parameter int NUM_BITS   = 16,
    parameter int NUM_STAGES = 1,
    parameter bit EN_RESET   = 1'b0,
    parameter int CNT_W      = occ_width(NUM_STAGES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_BITS-1:0] data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    occupancy
`ifdef ELASTIC_PIPE_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    logic w_flush;

`ifdef ELASTIC_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    generate
        if (NUM_STAGES == 0) begin : g_bypass
            assign data_out  = data_in;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign occupancy = '0;
        end else begin : g_pipe
            logic [NUM_STAGES-1:0] w_rdy;
            logic [NUM_STAGES-1:0] w_valid;
            logic [NUM_BITS-1:0]   w_data [NUM_STAGES];
            logic                  w_accept;
            logic                  w_emit;
            logic [CNT_W-1:0]      r_occ;

            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
                logic                w_in_valid;
                logic [NUM_BITS-1:0] w_in_data;
                if (i == 0) begin : g_head
                    assign w_in_valid = in_valid;
                    assign w_in_data  = data_in;
                end else begin : g_body
                    assign w_in_valid = w_valid[i-1];
                    assign w_in_data  = w_data[i-1];
                end
                // Unrolled ready chain: a stage can move unless it and every stage downstream are full and the consumer stalls
                assign w_rdy[i] = out_ready | ~&w_valid[NUM_STAGES-1:i];
                pipe_stage #(
                    .NUM_BITS (NUM_BITS),
                    .EN_RESET (EN_RESET)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .i_load  (w_rdy[i]),
                    .i_clear (w_flush),
                    .i_valid (w_in_valid),
                    .i_data  (w_in_data),
                    .o_valid (w_valid[i]),
                    .o_data  (w_data[i])
                );
            end

            assign in_ready  = w_rdy[0] & ~w_flush;
            assign out_valid = w_valid[NUM_STAGES-1] & ~w_flush;
            assign data_out  = w_data[NUM_STAGES-1];
            assign w_accept  = in_valid & in_ready;
            assign w_emit    = out_valid & out_ready;

            // Occupancy tracks accepts minus emits so it always equals the number of valid stages
            always_ff @(posedge clk) begin
                if (rst || w_flush) r_occ <= '0;
                else if (w_accept && !w_emit) r_occ <= r_occ + CNT_W'(1);
                else if (!w_accept && w_emit) r_occ <= r_occ - CNT_W'(1);
            end

            assign occupancy = r_occ;
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed checks of N=3/N=4/N=0 pipelines against a queue model
module tb_elastic_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, flush;
    logic [15:0] data_in;
    logic        rdy3, ov3, rdy4, ov4;
    logic [15:0] do3, do4;
    logic [1:0]  occ3;
    logic [2:0]  occ4;
    logic        z_valid, z_oready, z_rdy, z_ov;
    logic [15:0] z_in, z_out;
    logic [0:0]  z_occ;
    int          n_chk = 0;
    int          n_fail = 0;

    elastic_pipeline #(.NUM_BITS(16), .NUM_STAGES(3), .EN_RESET(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy3),
        .data_out(do3), .out_valid(ov3), .out_ready(out_ready), .occupancy(occ3)
`ifdef ELASTIC_PIPE_FLUSH_EN
        , .flush(flush)
`endif
    );

    elastic_pipeline #(.NUM_BITS(16), .NUM_STAGES(4), .EN_RESET(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy4),
        .data_out(do4), .out_valid(ov4), .out_ready(out_ready), .occupancy(occ4)
`ifdef ELASTIC_PIPE_FLUSH_EN
        , .flush(flush)
`endif
    );

    elastic_pipeline #(.NUM_BITS(16), .NUM_STAGES(0), .EN_RESET(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(z_in), .in_valid(z_valid), .in_ready(z_rdy),
        .data_out(z_out), .out_valid(z_ov), .out_ready(z_oready), .occupancy(z_occ)
`ifdef ELASTIC_PIPE_FLUSH_EN
        , .flush(flush)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an N-stage elastic pipe is a FIFO of capacity N whose head becomes visible
    // once it has been inside for N-1 edges; it can take an item whenever it is not full
    // or the consumer is taking one out this cycle.
    logic [15:0] md [2][8];
    int          ma [2][8];
    int          mc [2] = '{0, 0};

    function automatic int ns(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic logic m_rdy(input int d);
        return !flush && (out_ready || mc[d] < ns(d));
    endfunction

    function automatic logic m_ov(input int d);
        return !flush && mc[d] > 0 && ma[d][0] >= ns(d) - 1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic acc, em;
            acc = in_valid && m_rdy(d);
            em  = m_ov(d) && out_ready;
            if (rst || flush) begin
                mc[d] = 0;
            end else begin
                for (int i = 0; i < mc[d]; i++) ma[d][i]++;
                if (em) begin
                    for (int i = 1; i < mc[d]; i++) begin
                        md[d][i-1] = md[d][i];
                        ma[d][i-1] = ma[d][i];
                    end
                    mc[d]--;
                end
                if (acc) begin
                    md[d][mc[d]] = data_in;
                    ma[d][mc[d]] = 0;
                    mc[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready N3", 32'(rdy3), 32'(m_rdy(0)));
            chk("out_valid N3", 32'(ov3), 32'(m_ov(0)));
            chk("occupancy N3", 32'(occ3), mc[0]);
            if (m_ov(0)) chk("data_out N3", 32'(do3), 32'(md[0][0]));
            chk("in_ready N4", 32'(rdy4), 32'(m_rdy(1)));
            chk("out_valid N4", 32'(ov4), 32'(m_ov(1)));
            chk("occupancy N4", 32'(occ4), mc[1]);
            if (m_ov(1)) chk("data_out N4", 32'(do4), 32'(md[1][0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] vals [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    logic        pat  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int em4;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; data_in = '0;
        z_valid = 1'b0; z_oready = 1'b0; z_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 32'(ov3), 0);
        chk("reset occupancy", 32'(occ3), 0);
        chk("reset in_ready", 32'(rdy3), 1);
        chk("reset data_out", 32'(do3), 0);
        step();

        // Back-to-back stream with the consumer always ready
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1; data_in = 16'(k);
            @(negedge clk);
            chk("stream out_valid N3", 32'(ov3), 32'(k >= 4));
            if (k >= 4) chk("stream data N3", 32'(do3), k - 3);
            chk("stream occupancy N3", 32'(occ3), (k - 1 < 3) ? k - 1 : 3);
            chk("stream out_valid N4", 32'(ov4), 32'(k >= 5));
            if (k >= 5) chk("stream data N4", 32'(do4), k - 4);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();

        // Fill against a stalled consumer, then release it
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; data_in = vals[k];
            @(negedge clk);
            if (k == 3) begin
                chk("full in_ready", 32'(rdy3), 0);
                chk("full occupancy", 32'(occ3), 3);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", 32'(rdy3), 1);
        chk("release out_valid", 32'(ov3), 1);
        chk("release data_out", 32'(do3), 32'h000A);
        chk("release occupancy", 32'(occ3), 3);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("after swap occupancy", 32'(occ3), 3);
        chk("after swap data_out", 32'(do3), 32'h000B);
        step();
        out_ready = 1'b1;
        repeat (8) step();

        // Single item with a toggling consumer
        in_valid = 1'b1; data_in = 16'h0055; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        em4 = 0;
        for (int j = 0; j < 8; j++) begin
            out_ready = pat[j];
            @(negedge clk);
            if (ov4 && out_ready) em4++;
            if (j == 3) begin
                chk("stall out_valid N4", 32'(ov4), 1);
                chk("stall data_out N4", 32'(do4), 32'h0055);
            end
            step();
        end
        chk("single emit count N4", em4, 1);
        chk("single drained N4", 32'(occ4), 0);

        // Reset while full discards everything
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; data_in = 16'(k * 16'h0011);
            step();
        end
        rst = 1'b1; data_in = 16'h0044;
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midreset out_valid", 32'(ov3), 0);
        chk("midreset occupancy", 32'(occ3), 0);
        chk("midreset in_ready", 32'(rdy3), 1);
        chk("midreset data_out", 32'(do3), 0);
        chk("midreset occupancy N4", 32'(occ4), 0);
        step();

`ifdef ELASTIC_PIPE_FLUSH_EN
        // Flush two held items while a producer is waiting
        out_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            in_valid = 1'b1; data_in = 16'(k);
            step();
        end
        flush = 1'b1; in_valid = 1'b1; data_in = 16'h0099;
        @(negedge clk);
        chk("flush in_ready", 32'(rdy3), 0);
        chk("flush out_valid", 32'(ov3), 0);
        step();
        flush = 1'b0; data_in = 16'h0077;
        @(negedge clk);
        chk("post flush occupancy", 32'(occ3), 0);
        chk("post flush in_ready", 32'(rdy3), 1);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int i = 1; i <= 10 && seen == 0; i++) begin
            @(negedge clk);
            if (ov3) begin
                seen = i;
                chk("post flush data", 32'(do3), 32'h0077);
            end
            step();
        end
        chk("post flush latency", seen, 3);
`endif

        // Zero-stage passthrough
        for (int i = 0; i < 20; i++) begin
            z_valid = 1'($urandom); z_oready = 1'($urandom); z_in = 16'($urandom);
            #1;
            chk("bypass data_out", 32'(z_out), 32'(z_in));
            chk("bypass out_valid", 32'(z_ov), 32'(z_valid));
            chk("bypass in_ready", 32'(z_rdy), 32'(z_oready));
            chk("bypass occupancy", 32'(z_occ), 0);
            #2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
